// File: rtl/i2c_scl_gen_pkg.sv
// Shared constants and phase encoding for the 4-phase I2C SCL timing generator.
// Phases 0/1 hold SCL low, phases 2/3 release it high.
package i2c_scl_gen_pkg;

   localparam int I2C_CNT_W       = 16;
   localparam int I2C_DEFAULT_DIV = 30;

   typedef enum logic [1:0] {
      PH_LOW0  = 2'd0,
      PH_LOW1  = 2'd1,
      PH_HIGH0 = 2'd2,
      PH_HIGH1 = 2'd3
   } phase_e;

   function automatic phase_e phase_inc(input phase_e p);
      return phase_e'(p + 2'd1);
   endfunction

   function automatic logic phase_is_high(input phase_e p);
      return (p == PH_HIGH0) || (p == PH_HIGH1);
   endfunction

endpackage

// File: rtl/i2c_scl_gen_if.sv
// Control/status bundle between the I2C bit engine (master side) and the SCL
// timing generator (slave side).
interface i2c_scl_gen_if
   import i2c_scl_gen_pkg::*;
#(
   parameter int CNT_W = I2C_CNT_W
);

   logic             en;
   logic             div_wr;
   logic [CNT_W-1:0] div_in;
   logic             stretch_hold;

   logic [CNT_W-1:0] div_q;
   logic             div_pend;
   logic             tick;
   logic             period_end;
   logic [1:0]       phase;
   logic             scl_o;
   logic             stretching;

   modport master (
      output en,
      output div_wr,
      output div_in,
      output stretch_hold,
      input  div_q,
      input  div_pend,
      input  tick,
      input  period_end,
      input  phase,
      input  scl_o,
      input  stretching
   );

   modport slave (
      input  en,
      input  div_wr,
      input  div_in,
      input  stretch_hold,
      output div_q,
      output div_pend,
      output tick,
      output period_end,
      output phase,
      output scl_o,
      output stretching
   );

endinterface

// File: rtl/i2c_scl_gen_div_counter.sv
// Quarter-phase counter: counts 0..div_act-1, flags terminal count, can be frozen,
// and owns the divisor currently in effect.
module i2c_scl_gen_div_counter
   import i2c_scl_gen_pkg::*;
#(
   parameter int CNT_W       = I2C_CNT_W,
   parameter int DEFAULT_DIV = I2C_DEFAULT_DIV
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             start_i,
   input  logic             freeze_i,
   input  logic             div_ld_i,
   input  logic [CNT_W-1:0] div_ld_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] div_act_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] div_act_q;
   logic [CNT_W-1:0] div_act_d;
   logic             at_term;

   // div_act is never 0, so the subtraction cannot wrap
   assign at_term = (cnt_q == (div_act_q - CNT_W'(1)));
   // The first edge of a run only restarts the count; it never ends a phase
   assign tc_o    = en_i & ~start_i & ~freeze_i & at_term;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || start_i || tc_o) begin
         cnt_d = '0;
      end else if (!freeze_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      div_act_d = div_ld_i ? div_ld_val_i : div_act_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         div_act_q <= CNT_W'(DEFAULT_DIV);
      end else begin
         cnt_q     <= cnt_d;
         div_act_q <= div_act_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign div_act_o = div_act_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// Runtime-programmable 4-phase SCL timing generator with period-aligned divisor
// reload and clock-stretch hold at the start of the first SCL-high phase.
module i2c_scl_gen
   import i2c_scl_gen_pkg::*;
#(
   parameter int CNT_W       = I2C_CNT_W,
   parameter int DEFAULT_DIV = I2C_DEFAULT_DIV
)
(
   input  logic        clk,
   input  logic        rst,
   i2c_scl_gen_if.slave bus
);

   function automatic logic [CNT_W-1:0] sat_div(input logic [CNT_W-1:0] d);
      return (d == '0) ? CNT_W'(1) : d;
   endfunction

   logic             run_q;
   logic             run_d;
   phase_e           phase_q;
   phase_e           phase_d;
   logic             pend_q;
   logic             pend_d;
   logic [CNT_W-1:0] pend_val_q;
   logic [CNT_W-1:0] pend_val_d;
   logic             tick_q;
   logic             tick_d;
   logic             period_end_q;
   logic             period_end_d;
   logic             scl_q;
   logic             scl_d;
   logic             stretching_q;
   logic             stretching_d;

   logic             start;
   logic             freeze;
   logic             tc;
   logic             wrap;
   logic             div_ld;
   logic [CNT_W-1:0] div_wr_val;
   logic [CNT_W-1:0] div_ld_val;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_act;

   assign start  = bus.en & ~run_q;
   // Stretch is only honoured on the first cycle of phase 2, while SCL is released
   assign freeze = bus.en & run_q & (phase_q == PH_HIGH0) & (cnt == '0) & bus.stretch_hold;
   assign wrap   = tc & (phase_q == PH_HIGH1);

   assign div_wr_val = sat_div(bus.div_in);
   // Idle writes take effect at once; running writes wait for the period wrap
   assign div_ld     = (bus.div_wr & ~bus.en) | (wrap & (bus.div_wr | pend_q));
   assign div_ld_val = bus.div_wr ? div_wr_val : pend_val_q;

   i2c_scl_gen_div_counter #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_div_counter (
      .clk          (clk),
      .rst          (rst),
      .en_i         (bus.en),
      .start_i      (start),
      .freeze_i     (freeze),
      .div_ld_i     (div_ld),
      .div_ld_val_i (div_ld_val),
      .cnt_o        (cnt),
      .div_act_o    (div_act),
      .tc_o         (tc)
   );

   always_comb begin
      run_d   = bus.en;
      phase_d = phase_q;
      if (!bus.en || start) begin
         phase_d = PH_LOW0;
      end else if (tc) begin
         phase_d = phase_inc(phase_q);
      end

      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      if (!bus.en && bus.div_wr) begin
         pend_d = 1'b0;
      end else if (wrap) begin
         pend_d = 1'b0;
      end else if (bus.en && bus.div_wr) begin
         pend_d     = 1'b1;
         pend_val_d = div_wr_val;
      end

      tick_d       = tc;
      period_end_d = wrap;
      scl_d        = bus.en ? phase_is_high(phase_d) : 1'b1;
      stretching_d = freeze;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q        <= 1'b0;
         phase_q      <= PH_LOW0;
         pend_q       <= 1'b0;
         pend_val_q   <= CNT_W'(DEFAULT_DIV);
         tick_q       <= 1'b0;
         period_end_q <= 1'b0;
         scl_q        <= 1'b1;
         stretching_q <= 1'b0;
      end else begin
         run_q        <= run_d;
         phase_q      <= phase_d;
         pend_q       <= pend_d;
         pend_val_q   <= pend_val_d;
         tick_q       <= tick_d;
         period_end_q <= period_end_d;
         scl_q        <= scl_d;
         stretching_q <= stretching_d;
      end
   end

   assign bus.div_q      = div_act;
   assign bus.div_pend   = pend_q;
   assign bus.tick       = tick_q;
   assign bus.period_end = period_end_q;
   assign bus.phase      = phase_q;
   assign bus.scl_o      = scl_q;
   assign bus.stretching = stretching_q;

endmodule
